fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Generates sequential word PCs,
//               issues requests to instruction memory, tags each in-order
//               response with the PC it was fetched from, buffers the tagged
//               words and hands them to the instruction fifo over
//               valid/ready. A redirect retargets the PC and discards every
//               response still owed for requests issued before it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i             in   1      clock
//   rst_ni            in   1      asynchronous active-low reset
//   redirect_valid_i  in   1      redirect fetch this cycle
//   redirect_pc_i     in   Width  new fetch target (low two bits ignored)
//   imem_req_valid_o  out  1      memory request valid
//   imem_req_addr_o   out  Width  request word address (current PC)
//   imem_req_ready_i  in   1      memory accepts request
//   imem_rsp_valid_i  in   1      response valid (in order, no backpressure)
//   imem_rsp_data_i   in   Width  returned instruction word
//   out_valid_o       out  1      tagged instruction available
//   out_pc_o          out  Width  PC of out_instr_o
//   out_instr_o       out  Width  instruction word
//   out_ready_i       in   1      downstream accepts
// ============================================================================
module fetch_unit #(
  parameter int unsigned      Width     = 32,
  parameter logic [Width-1:0] ResetPc   = '0,
  parameter int unsigned      DepthLog2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             redirect_valid_i,
  input  logic [Width-1:0] redirect_pc_i,
  output logic             imem_req_valid_o,
  output logic [Width-1:0] imem_req_addr_o,
  input  logic             imem_req_ready_i,
  input  logic             imem_rsp_valid_i,
  input  logic [Width-1:0] imem_rsp_data_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_pc_o,
  output logic [Width-1:0] out_instr_o,
  input  logic             out_ready_i
);

  localparam int                   c_DEPTH   = 2 ** DepthLog2;
  localparam int                   c_CW      = DepthLog2 + 1;
  localparam int                   c_OW      = c_CW + 1;
  localparam logic [c_OW-1:0]      c_OCC_MAX = c_OW'(c_DEPTH);
  localparam logic [c_CW-1:0]      c_CNT_ONE = c_CW'(1);
  localparam logic [DepthLog2-1:0] c_PTR_ONE = DepthLog2'(1);
  localparam logic [Width-1:0]     c_PC_STEP = Width'(4);

  // Control state
  logic                 r_run;
  logic [Width-1:0]     r_pc;
  logic [c_CW-1:0]      r_inflight;
  logic [c_CW-1:0]      r_drop;
  logic [c_CW-1:0]      r_buf_cnt;
  logic [DepthLog2-1:0] r_buf_rd;
  logic [DepthLog2-1:0] r_buf_wr;
  logic [DepthLog2-1:0] r_tag_rd;
  logic [DepthLog2-1:0] r_tag_wr;

  // Storage: response buffer and PC tag queue
  logic [Width-1:0]     r_buf_pc    [c_DEPTH];
  logic [Width-1:0]     r_buf_instr [c_DEPTH];
  logic [Width-1:0]     r_tag       [c_DEPTH];

  logic [c_OW-1:0]      w_occ;
  logic                 w_req_fire;
  logic                 w_pop;
  logic                 w_keep;
  logic [c_CW-1:0]      w_inflight_after_rsp;
  logic                 w_unused_pc_lsb;

  // Issue is throttled on outstanding requests plus buffered words, so every
  // response that arrives is guaranteed a free buffer slot.
  assign w_occ            = {1'b0, r_inflight} + {1'b0, r_buf_cnt};
  assign imem_req_valid_o = r_run && !redirect_valid_i && (w_occ < c_OCC_MAX);
  assign imem_req_addr_o  = r_pc;
  assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

  // Outputs come only from registered buffer state: no path from imem_rsp_*.
  assign out_valid_o      = (r_buf_cnt != '0) && !redirect_valid_i;
  assign out_pc_o         = r_buf_pc[r_buf_rd];
  assign out_instr_o      = r_buf_instr[r_buf_rd];
  assign w_pop            = out_valid_o && out_ready_i;

  // A response is kept only if it is not owed to a pre-redirect request and
  // does not itself coincide with a redirect.
  assign w_keep           = imem_rsp_valid_i && !redirect_valid_i && (r_drop == '0);

  assign w_inflight_after_rsp = r_inflight - c_CW'(imem_rsp_valid_i);

  // The redirect target is forced word-aligned.
  assign w_unused_pc_lsb  = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run      <= 1'b0;
      r_pc       <= ResetPc;
      r_inflight <= '0;
      r_drop     <= '0;
      r_buf_cnt  <= '0;
      r_buf_rd   <= '0;
      r_buf_wr   <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
    end else begin
      r_run <= 1'b1;

      // Every response retires the oldest tag, whether kept or dropped, so
      // the tag queue stays aligned with the memory's response order.
      if (imem_rsp_valid_i) begin
        r_tag_rd <= r_tag_rd + c_PTR_ONE;
      end

      if (redirect_valid_i) begin
        // Everything still outstanding belongs to the old path and must be
        // discarded on arrival; this also absorbs any earlier drop count.
        r_pc       <= {redirect_pc_i[Width-1:2], 2'b00};
        r_inflight <= w_inflight_after_rsp;
        r_drop     <= w_inflight_after_rsp;
        r_buf_cnt  <= '0;
        r_buf_rd   <= r_buf_wr;
      end else begin
        if (w_req_fire) begin
          r_pc     <= r_pc + c_PC_STEP;
          r_tag_wr <= r_tag_wr + c_PTR_ONE;
        end
        r_inflight <= r_inflight + c_CW'(w_req_fire) - c_CW'(imem_rsp_valid_i);
        if (imem_rsp_valid_i && (r_drop != '0)) begin
          r_drop <= r_drop - c_CNT_ONE;
        end
        if (w_keep) begin
          r_buf_wr <= r_buf_wr + c_PTR_ONE;
        end
        if (w_pop) begin
          r_buf_rd <= r_buf_rd + c_PTR_ONE;
        end
        r_buf_cnt <= r_buf_cnt + c_CW'(w_keep) - c_CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_tag[i]       <= '0;
        r_buf_pc[i]    <= '0;
        r_buf_instr[i] <= '0;
      end
    end else begin
      if (w_req_fire) begin
        r_tag[r_tag_wr] <= r_pc;
      end
      if (w_keep) begin
        r_buf_pc[r_buf_wr]    <= r_tag[r_tag_rd];
        r_buf_instr[r_buf_wr] <= imem_rsp_data_i;
      end
    end
  end

`ifndef SYNTHESIS
  a_rsp_has_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> (r_inflight != '0));
  a_occupancy_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_occ <= c_OCC_MAX);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A queue-based model of
//               the memory and of the words owed to the fifo predicts the
//               handshake signals and the tagged output stream each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        out_valid_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic        out_ready_i = 1'b0;

  fetch_unit #(
    .Width     (32),
    .ResetPc   (RESET_PC),
    .DepthLog2 (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .out_valid_o      (out_valid_o),
    .out_pc_o         (out_pc_o),
    .out_instr_o      (out_instr_o),
    .out_ready_i      (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: requests the memory still owes (stale = issued before
  // the latest redirect) and words owed to the fifo, oldest first.
  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] avail_q[$];
  logic [31:0] next_req;
  bit          run_m;

  int          n_checks;
  int          n_pass;
  int          n_fail;
  int          dut_hs;
  logic [31:0] hs_addr[$];
  logic [31:0] pop_pc[$];
  logic        s_req_valid;
  logic        s_out_valid;
  logic [31:0] s_req_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hxxxx_xxxx;
  endfunction

  // One clock cycle: called at a falling edge, drives inputs, checks the DUT
  // against the model, advances the model across the rising edge.
  task automatic cycle(input bit redir, input logic [31:0] tgt, input bit rdy,
                       input bit ordy, input bit rsp);
    bit          rsp_go;
    bit          exp_req;
    bit          exp_out;
    bit          rsp_stale;
    logic [31:0] rsp_addr;
    rsp_go    = rsp && (mem_q.size() != 0);
    rsp_stale = 1'b0;
    rsp_addr  = '0;
    redirect_valid_i = redir;
    redirect_pc_i    = tgt;
    imem_req_ready_i = rdy;
    out_ready_i      = ordy;
    imem_rsp_valid_i = rsp_go;
    imem_rsp_data_i  = rsp_go ? (mem_q[0].addr ^ KEY) : 32'hDEAD_BEEF;
    #1;
    exp_req = run_m && !redir && ((mem_q.size() + avail_q.size()) < DEPTH);
    exp_out = (avail_q.size() != 0) && !redir;
    chk("req_valid", 32'(imem_req_valid_o), 32'(exp_req));
    chk("out_valid", 32'(out_valid_o), 32'(exp_out));
    if (exp_req) chk("req_addr", imem_req_addr_o, next_req);
    if (exp_out) begin
      chk("out_pc", out_pc_o, avail_q[0]);
      chk("out_instr", out_instr_o, avail_q[0] ^ KEY);
    end
    s_req_valid = imem_req_valid_o;
    s_req_addr  = imem_req_addr_o;
    s_out_valid = out_valid_o;
    if ((imem_req_valid_o === 1'b1) && rdy) begin
      dut_hs++;
      hs_addr.push_back(imem_req_addr_o);
    end
    if ((out_valid_o === 1'b1) && ordy) pop_pc.push_back(out_pc_o);

    if (rsp_go) begin
      rsp_stale = mem_q[0].stale;
      rsp_addr  = mem_q[0].addr;
      void'(mem_q.pop_front());
    end
    if (redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      avail_q.delete();
      next_req = {tgt[31:2], 2'b00};
    end else begin
      if (exp_out && ordy) void'(avail_q.pop_front());
      if (rsp_go && !rsp_stale) avail_q.push_back(rsp_addr);
      if (exp_req && rdy) begin
        mem_q.push_back('{addr: next_req, stale: 1'b0});
        next_req = next_req + 32'd4;
      end
    end
    run_m = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic reset_dut(input bit mid_cycle);
    if (mid_cycle) #2;
    rst_ni           = 1'b0;
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    out_ready_i      = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    mem_q.delete();
    avail_q.delete();
    next_req = RESET_PC;
    run_m    = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_hold_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("rst_hold_out_valid", 32'(out_valid_o), 32'd0);
    rst_ni = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    dut_hs   = 0;

    // Reset, then streaming fetch with an always-ready memory and fifo.
    reset_dut(1'b0);
    hs_addr.delete();
    pop_pc.delete();
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("p1_req0", qget(hs_addr, 0), 32'h0);
    chk("p1_req1", qget(hs_addr, 1), 32'h4);
    chk("p1_pop0", qget(pop_pc, 0), 32'h0);
    chk("p1_pop1", qget(pop_pc, 1), 32'h4);

    // Stalled fifo: exactly Depth requests, then one pop frees one slot.
    reset_dut(1'b0);
    dut_hs = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("p2_req_count", 32'(dut_hs), 32'd4);
    dut_hs = 0;
    hs_addr.delete();
    pop_pc.delete();
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("p2_pop_count", 32'(pop_pc.size()), 32'd1);
    chk("p2_pop_pc", qget(pop_pc, 0), 32'h0);
    chk("p2_new_req_count", 32'(dut_hs), 32'd1);
    chk("p2_new_req_addr", qget(hs_addr, 0), 32'h10);

    // Three requests in flight, then redirect to 0x100.
    reset_dut(1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
      chk("p3_stale_out_valid", 32'(s_out_valid), 32'd0);
    end
    pop_pc.delete();
    for (int i = 0; i < 20 && pop_pc.size() == 0; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("p3_first_pc", qget(pop_pc, 0), 32'h100);

    // Unaligned target, then redirect over a full buffer.
    cycle(1'b1, 32'h103, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("p4_req_valid", 32'(s_req_valid), 32'd1);
    chk("p4_aligned_addr", s_req_addr, 32'h100);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    chk("p4_redirect_out_valid", 32'(s_out_valid), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("p4_flushed_out_valid", 32'(s_out_valid), 32'd0);

    // Response arriving together with a redirect is dropped.
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
      chk("p5_dropped_out_valid", 32'(s_out_valid), 32'd0);
    end
    pop_pc.delete();
    for (int i = 0; i < 20 && pop_pc.size() == 0; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("p5_first_pc", qget(pop_pc, 0), 32'h300);

    // PC wrap, then asynchronous reset in the middle of a burst.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
    hs_addr.delete();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("p6_wrap_req0", qget(hs_addr, 0), 32'hFFFF_FFFC);
    chk("p6_wrap_req1", qget(hs_addr, 1), 32'h0);
    reset_dut(1'b1);
    hs_addr.delete();
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("p6_restart_pc", qget(hs_addr, 0), RESET_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 100) < 4, $urandom, ($urandom % 100) < 70,
            ($urandom % 100) < 60, ($urandom % 100) < 60);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
